local_mem_arbiter: RTL and testbench
====================================

# local_mem_arbiter

Shares one single-port, 1-cycle-read-latency local memory between `NUM_PORTS` requesters, for example the load/store memory sub-unit and a debug or DMA port. Each cycle it picks at most one requester, by round-robin or fixed priority, and drives that request onto the memory port. A grant lock keeps ownership across multi-cycle sequences, such as an AMO read followed by its write-back. It routes each read response to the port that issued it and sits between the requesters' local-memory ports and the memory block.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of requesters, minimum 2.
- `FIXED_PRIORITY`, 0: 0 = round-robin; 1 = lowest index always wins.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `req`  in  NUM_PORTS  per-port request; held until granted.
- `lock`  in  NUM_PORTS  with `req`: keep grant for this port after this access.
- `addr`  in  NUM_PORTS×30  word address per port.
- `be`  in  NUM_PORTS×4  byte enables; 0 = read.
- `wdata`  in  NUM_PORTS×32  write data.
- `gnt`  out  NUM_PORTS  one-hot grant, same cycle as accepted `req`.
- `rvalid`  out  NUM_PORTS  read response strobe, registered.
- `rdata`  out  32  shared read data (`mem_data_out`).
- `mem_en`, `mem_addr[29:0]`, `mem_be[3:0]`, `mem_data_in[31:0]`  out  memory request.
- `mem_data_out`  in  32  memory read data, valid 1 cycle after `mem_en` with `mem_be`=0.

## Operation
- **Request phase:** a request is accepted when `req[i]` and `gnt[i]` are both 1.
  - The mux drives `mem_addr`/`mem_be`/`mem_data_in` from the granted port.
  - `mem_en` = |`gnt`.
  - With no grant, `mem_en`=0 and the data outputs are don't-care.
- **Selection, no lock active:**
  - Round-robin: search starts at `last+1` modulo `NUM_PORTS`; the first requesting port wins.
  - `last` updates to the winner on every grant.
  - With `FIXED_PRIORITY`=1: the lowest requesting index wins and `last` is unused.
- **Lock:**
  - The lock becomes active at the clock edge after a grant with `lock[i]`=1.
  - Lock state: `lock_active`, `lock_owner`.
  - While the lock is active, only `lock_owner` can be granted. Other requests wait, even when the owner idles.
  - An owner idle cycle gives `mem_en`=0.
  - The lock clears at the edge after an owner grant with `lock`=0. That access itself is still granted.
  - There is no timeout. Requesters must not hold the lock indefinitely.
- **Response:** `rvalid[i]` is 1 in the cycle after port i was granted with `be`=0, otherwise 0. Writes produce no response.
- **Reset:** `rst`=0 for any cycle forces the following, even mid-lock or mid-read:
  - `gnt`=0 and `mem_en`=0 that cycle.
  - `rvalid`←0; any in-flight response is dropped.
  - `lock_active`←0.
  - `last`←`NUM_PORTS`-1, so port 0 wins first after reset.

## Timing
- Grant path is combinational from `req`, `lock_active`, `lock_owner`, `last`.
- Memory access happens in the grant cycle; `rvalid`/`rdata` follow 1 cycle later.
- Throughput: one access per cycle, back-to-back across ports or from the same port.
- Locked pair (read lock=1, then write lock=0) occupies 2 consecutive cycles when the owner requests continuously.
- Round-robin worst-case wait: `NUM_PORTS`-1 grants, plus any lock duration.
- Simultaneous events:
  - Owner releases lock and another port requests in the same cycle: the owner is granted that cycle, the other port is eligible next cycle.
  - Single requester: it is granted every cycle.

## Structure
- In shared package `cva5_types`:
  - `typedef struct packed {logic [29:0] addr; logic [3:0] be; logic [31:0] data;} local_mem_req_t`.
  - Ports use arrays of this struct internally.
- Sub-module `local_mem_rr_select` (combinational):
  - Inputs: `req` vector, `last` index, `FIXED_PRIORITY`.
  - Outputs: one-hot winner and winner index.
- Top-level contents:
  - lock state;
  - `last` register;
  - `rvalid` register;
  - output mux.

## Test plan
1. **Round-robin reads:** after reset, ports 0 and 1 request reads of 0x10 and 0x20 continuously. Required: `gnt` = 01, then 10, then 01; `rvalid` = 01 on cycle 1 with `rdata`=mem[0x10], 10 on cycle 2 with `rdata`=mem[0x20].
2. **Locked RMW:** port 0 reads 0x8 with lock=1 while port 1 requests. Required: cycle 1 grants port 0 write (`be`=F, lock=0, data 0x1234); port 1 is granted on cycle 2; mem[0x8]=0x1234.
3. **Owner idle under lock:** lock active, owner `req`=0, port 1 `req`=1 for 3 cycles. Required: `mem_en`=0, `gnt`=0 throughout; port 1 is granted the cycle after owner release.
4. **Write has no response:** port 1 writes with `be`=4'h3. Required: `mem_be`=3, `rvalid` stays 00 on the next cycle.
5. **Reset mid-lock with read in flight:** `rst`=0 for 1 cycle. Required: `rvalid`=00 next cycle, lock cleared, first grant after reset goes to port 0 with both requesting.
6. **Fixed priority:** `FIXED_PRIORITY`=1 with both ports requesting for 4 cycles. Required: `gnt`=01 every cycle; port 1 is never granted.

Source files
------------

// File: rtl/local_mem_arbiter_pkg.sv
// Shared types for the local-memory arbiter: one request record per port.
package cva5_types;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } local_mem_req_t;

endpackage

// File: rtl/local_mem_rr_select.sv
// Combinational winner select: round-robin starting after last, or lowest
// requesting index when FIXED_PRIORITY is set.
module local_mem_rr_select #(
    parameter int NUM_PORTS      = 2,
    parameter bit FIXED_PRIORITY = 1'b0,
    localparam int IDX_W         = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_i,
    output logic [NUM_PORTS-1:0] winner_o,
    output logic [IDX_W-1:0]     winner_idx_o
);

    logic found;
    int   idx;

    always_comb begin
        winner_o     = '0;
        winner_idx_o = '0;
        found        = 1'b0;
        idx          = 0;
        if (FIXED_PRIORITY) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req_i[i] && !found) begin
                    found        = 1'b1;
                    winner_o[i]  = 1'b1;
                    winner_idx_o = IDX_W'(i);
                end
            end
        end else begin
            // Offset NUM_PORTS wraps back to last itself, so a lone requester always wins.
            for (int off = 1; off <= NUM_PORTS; off++) begin
                idx = (int'(last_i) + off) % NUM_PORTS;
                if (req_i[idx] && !found) begin
                    found          = 1'b1;
                    winner_o[idx]  = 1'b1;
                    winner_idx_o   = IDX_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/local_mem_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one single-port, 1-cycle-latency local
// memory, with a grant lock for multi-cycle sequences and read-response routing.
module local_mem_arbiter
    import cva5_types::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       req,
    input  logic [NUM_PORTS-1:0]       lock,
    input  logic [NUM_PORTS-1:0][29:0] addr,
    input  logic [NUM_PORTS-1:0][3:0]  be,
    input  logic [NUM_PORTS-1:0][31:0] wdata,
    output logic [NUM_PORTS-1:0]       gnt,
    output logic [NUM_PORTS-1:0]       rvalid,
    output logic [31:0]                rdata,
    output logic                       mem_en,
    output logic [29:0]                mem_addr,
    output logic [3:0]                 mem_be,
    output logic [31:0]                mem_data_in,
    input  logic [31:0]                mem_data_out
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    local_mem_req_t        port_req [NUM_PORTS];
    local_mem_req_t        sel_req;
    logic [NUM_PORTS-1:0]  port_is_read;
    logic [NUM_PORTS-1:0]  eligible;
    logic [NUM_PORTS-1:0]  winner;
    logic [IDX_W-1:0]      winner_idx;

    logic [IDX_W-1:0]      last_q, last_d;
    logic [IDX_W-1:0]      lock_owner_q, lock_owner_d;
    logic                  lock_active_q, lock_active_d;
    logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_req[gi]     = '{addr: addr[gi], be: be[gi], data: wdata[gi]};
            assign port_is_read[gi] = (be[gi] == 4'h0);
        end
    endgenerate

    // Under lock only the owner may compete; others wait even if the owner idles.
    always_comb begin
        eligible = req;
        if (lock_active_q) begin
            eligible               = '0;
            eligible[lock_owner_q] = req[lock_owner_q];
        end
    end

    local_mem_rr_select #(
        .NUM_PORTS      (NUM_PORTS),
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_select (
        .req_i        (eligible),
        .last_i       (last_q),
        .winner_o     (winner),
        .winner_idx_o (winner_idx)
    );

    assign gnt         = rst ? winner : '0;
    assign mem_en      = |gnt;
    assign sel_req     = port_req[winner_idx];
    assign mem_addr    = sel_req.addr;
    assign mem_be      = sel_req.be;
    assign mem_data_in = sel_req.data;
    assign rvalid      = rvalid_q;
    assign rdata       = mem_data_out;

    always_comb begin
        last_d        = last_q;
        lock_owner_d  = lock_owner_q;
        lock_active_d = lock_active_q;
        rvalid_d      = gnt & port_is_read;
        if (mem_en) begin
            last_d        = winner_idx;
            lock_owner_d  = winner_idx;
            lock_active_d = lock[winner_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q        <= IDX_W'(NUM_PORTS - 1);
            lock_owner_q  <= '0;
            lock_active_q <= 1'b0;
            rvalid_q      <= '0;
        end else begin
            last_q        <= last_d;
            lock_owner_q  <= lock_owner_d;
            lock_active_q <= lock_active_d;
            rvalid_q      <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_local_mem_arbiter.sv
// Directed bench for local_mem_arbiter: vector table for arbitration/lock/response
// behaviour, hand sequences for reset-mid-lock and fixed priority.
module tb_local_mem_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req, lock;
    logic [1:0][29:0] addr;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] wdata;

    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    logic [1:0]  fp_gnt, fp_rvalid;
    logic [31:0] fp_rdata;
    logic        fp_mem_en;
    logic [29:0] fp_mem_addr;
    logic [3:0]  fp_mem_be;
    logic [31:0] fp_mem_data_in;
    logic [31:0] fp_mem_data_out;

    logic [31:0] mem [256];
    logic        mem_load;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign fp_mem_data_out = 32'h0;

    local_mem_arbiter #(.NUM_PORTS(2), .FIXED_PRIORITY(1'b0)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr), .be(be), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    local_mem_arbiter #(.NUM_PORTS(2), .FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr), .be(be), .wdata(wdata),
        .gnt(fp_gnt), .rvalid(fp_rvalid), .rdata(fp_rdata), .mem_en(fp_mem_en),
        .mem_addr(fp_mem_addr), .mem_be(fp_mem_be), .mem_data_in(fp_mem_data_in),
        .mem_data_out(fp_mem_data_out)
    );

    // Memory model: 1-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (mem_load) begin
            mem[8'h08] <= 32'h5555_0008;
            mem[8'h10] <= 32'hAAAA_0010;
            mem[8'h20] <= 32'hBBBB_0020;
            mem[8'h30] <= 32'h0000_0000;
            mem[8'h40] <= 32'h0000_0000;
        end else if (mem_en) begin
            if (mem_be == 4'h0) begin
                mem_data_out <= mem[mem_addr[7:0]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_data_in[b*8 +: 8];
                end
            end
        end
    end

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  lock;
        logic [3:0]  be0;
        logic [29:0] a0;
        logic [31:0] wd0;
        logic [3:0]  be1;
        logic [29:0] a1;
        logic [31:0] wd1;
        logic [1:0]  gnt;
        logic        chk_rv;
        logic [1:0]  rv;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic apply(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                         input logic [3:0] b0, input logic [29:0] ad0, input logic [31:0] w0,
                         input logic [3:0] b1, input logic [29:0] ad1, input logic [31:0] w1);
        @(posedge clk);
        #1;
        rst = r; req = rq; lock = lk;
        be[0] = b0; addr[0] = ad0; wdata[0] = w0;
        be[1] = b1; addr[1] = ad1; wdata[1] = w1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; req = '0; lock = '0; addr = '0; be = '0; wdata = '0;
        mem_load = 1'b1;

        //           rst   req    lock   be0   a0      wd0          be1   a1      wd1            gnt   crv   rv     crd   rd
        vecs[0]  = '{1'b0, 2'b11, 2'b00, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b00, 1'b0, 2'b00, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 2'b11, 2'b00, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b00, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 2'b11, 2'b00, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b01, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 2'b11, 2'b00, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b10, 1'b1, 2'b01, 1'b1, 32'hAAAA_0010};
        vecs[4]  = '{1'b1, 2'b11, 2'b00, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b01, 1'b1, 2'b10, 1'b1, 32'hBBBB_0020};
        vecs[5]  = '{1'b1, 2'b10, 2'b00, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b10, 1'b1, 2'b01, 1'b1, 32'hAAAA_0010};
        vecs[6]  = '{1'b1, 2'b11, 2'b01, 4'h0, 30'h08, 32'h0,       4'h0, 30'h20, 32'h0,         2'b01, 1'b1, 2'b10, 1'b1, 32'hBBBB_0020};
        vecs[7]  = '{1'b1, 2'b11, 2'b00, 4'hF, 30'h08, 32'h1234,    4'h0, 30'h20, 32'h0,         2'b01, 1'b1, 2'b01, 1'b1, 32'h5555_0008};
        vecs[8]  = '{1'b1, 2'b10, 2'b00, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b10, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 2'b11, 2'b01, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b01, 1'b1, 2'b10, 1'b1, 32'hBBBB_0020};
        vecs[10] = '{1'b1, 2'b10, 2'b00, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b00, 1'b1, 2'b01, 1'b1, 32'hAAAA_0010};
        vecs[11] = '{1'b1, 2'b10, 2'b00, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b00, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 2'b10, 2'b00, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b00, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 2'b11, 2'b00, 4'hF, 30'h30, 32'hCAFE,    4'h0, 30'h20, 32'h0,         2'b01, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 2'b10, 2'b00, 4'h0, 30'h10, 32'h0,       4'h3, 30'h40, 32'hFFFF_1111, 2'b10, 1'b1, 2'b00, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 2'b00, 2'b00, 4'h0, 30'h10, 32'h0,       4'h0, 30'h20, 32'h0,         2'b00, 1'b1, 2'b00, 1'b0, 32'h0};

        @(posedge clk);
        #1 mem_load = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].rst, vecs[i].req, vecs[i].lock,
                  vecs[i].be0, vecs[i].a0, vecs[i].wd0, vecs[i].be1, vecs[i].a1, vecs[i].wd1);
            $display("row %0d: req=%b gnt=%b mem_en=%b mem_be=%h rvalid=%b rdata=%h",
                     i, req, gnt, mem_en, mem_be, rvalid, rdata);
            chk($sformatf("r%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("r%0d_mem_en", i), 32'(mem_en), 32'(|vecs[i].gnt));
            if (vecs[i].gnt != 2'b00) begin
                chk($sformatf("r%0d_mem_addr", i), 32'(mem_addr),
                    32'(vecs[i].gnt[0] ? vecs[i].a0 : vecs[i].a1));
                chk($sformatf("r%0d_mem_be", i), 32'(mem_be),
                    32'(vecs[i].gnt[0] ? vecs[i].be0 : vecs[i].be1));
                if (mem_be != 4'h0)
                    chk($sformatf("r%0d_mem_data_in", i), mem_data_in,
                        vecs[i].gnt[0] ? vecs[i].wd0 : vecs[i].wd1);
            end
            if (vecs[i].chk_rv) chk($sformatf("r%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].rv));
            if (vecs[i].chk_rd) chk($sformatf("r%0d_rdata", i), rdata, vecs[i].rd);
        end

        chk("mem_0x08_rmw", mem[8'h08], 32'h0000_1234);
        chk("mem_0x30_write", mem[8'h30], 32'h0000_CAFE);
        chk("mem_0x40_partial", mem[8'h40], 32'h0000_1111);

        // Reset mid-lock with a read in flight; lock must be gone afterwards.
        apply(1'b1, 2'b01, 2'b01, 4'h0, 30'h10, 32'h0, 4'h0, 30'h20, 32'h0);
        $display("seq lock_grant: gnt=%b", gnt);
        chk("s5_lock_gnt", 32'(gnt), 32'h1);
        apply(1'b0, 2'b11, 2'b00, 4'h0, 30'h10, 32'h0, 4'h0, 30'h20, 32'h0);
        $display("seq reset: gnt=%b mem_en=%b rvalid=%b", gnt, mem_en, rvalid);
        chk("s5_rst_gnt", 32'(gnt), 32'h0);
        chk("s5_rst_mem_en", 32'(mem_en), 32'h0);
        chk("s5_rst_rvalid_pre", 32'(rvalid), 32'h1);
        apply(1'b1, 2'b10, 2'b00, 4'h0, 30'h10, 32'h0, 4'h0, 30'h20, 32'h0);
        $display("seq post_reset: gnt=%b rvalid=%b", gnt, rvalid);
        chk("s5_unlock_gnt", 32'(gnt), 32'h2);
        chk("s5_rvalid_cleared", 32'(rvalid), 32'h0);
        apply(1'b1, 2'b01, 2'b00, 4'h0, 30'h10, 32'h0, 4'h0, 30'h20, 32'h0);
        $display("seq port0_read: gnt=%b rvalid=%b rdata=%h", gnt, rvalid, rdata);
        chk("s5_p0_gnt", 32'(gnt), 32'h1);
        chk("s5_p1_rvalid", 32'(rvalid), 32'h2);
        chk("s5_p1_rdata", rdata, 32'hBBBB_0020);
        apply(1'b0, 2'b11, 2'b00, 4'h0, 30'h10, 32'h0, 4'h0, 30'h20, 32'h0);
        $display("seq reset2: gnt=%b fp_gnt=%b", gnt, fp_gnt);
        chk("s5_rst2_gnt", 32'(gnt), 32'h0);
        chk("s5_rst2_fp_gnt", 32'(fp_gnt), 32'h0);
        apply(1'b1, 2'b11, 2'b00, 4'h0, 30'h10, 32'h0, 4'h0, 30'h20, 32'h0);
        $display("seq first_after_reset: gnt=%b rvalid=%b fp_gnt=%b", gnt, rvalid, fp_gnt);
        chk("s5_first_gnt", 32'(gnt), 32'h1);
        chk("s5_dropped_rvalid", 32'(rvalid), 32'h0);
        chk("s6_fp_gnt0", 32'(fp_gnt), 32'h1);

        // Fixed priority holds port 0 while round-robin alternates.
        for (int c = 0; c < 4; c++) begin
            apply(1'b1, 2'b11, 2'b00, 4'h0, 30'h10, 32'h0, 4'h0, 30'h20, 32'h0);
            $display("seq both_req %0d: gnt=%b fp_gnt=%b", c, gnt, fp_gnt);
            chk($sformatf("s6_fp_gnt%0d", c + 1), 32'(fp_gnt), 32'h1);
            chk($sformatf("s6_rr_gnt%0d", c + 1), 32'(gnt), (c % 2 == 0) ? 32'h2 : 32'h1);
        end
        apply(1'b1, 2'b10, 2'b00, 4'h0, 30'h10, 32'h0, 4'h0, 30'h20, 32'h0);
        $display("seq p1_only: fp_gnt=%b", fp_gnt);
        chk("s6_fp_p1_only", 32'(fp_gnt), 32'h2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
